dem_element_decoder: RTL and testbench
======================================

DEM_ELEMENT_DECODER -- requirements
Module: dem_element_decoder

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 16: number of unit DAC elements driven by the switching tree.
REQ-002 SHALL have parameter WIDTH, default 5: code width, with 2^WIDTH >= NUM_ELEM+1.
REQ-003 SHALL have parameter WIN_LOG2, default 8: statistics window of 2^WIN_LOG2 valid samples.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port valid_i, input, 1 bit: elem_i and ref_value_i carry a sample this cycle.
REQ-007 SHALL have port elem_i, input, NUM_ELEM bits: unit-element enables from the switching tree, where bit k=1 means element k is on.
REQ-008 SHALL have port ref_value_i, input, WIDTH bits: quantized value that produced elem_i, aligned with it.
REQ-009 SHALL have port clear_stats_i, input, 1 bit: synchronous clear of all statistics.
REQ-010 SHALL have port valid_o, output, 1 bit: value_o and mismatch_o are valid this cycle.
REQ-011 SHALL have port value_o, output, WIDTH bits: reconstructed code, equal to the popcount of elem_i.
REQ-012 SHALL have port mismatch_o, output, 1 bit: value_o differs from ref_value_i for this sample.
REQ-013 SHALL have port err_count_o, output, 8 bits: saturating count of mismatched samples.
REQ-014 SHALL have port spread_o, output, WIN_LOG2+1 bits: max minus min element usage over the last completed window.
REQ-015 SHALL have port window_done_o, output, 1 bit: one-cycle pulse when spread_o is updated.

Function
REQ-016 SHALL use pipeline stage S1 to register valid_i, elem_i and ref_value_i.
REQ-017 SHALL use pipeline stage S2 to register popcount(S1 elem), compare it with S1 ref, and drive valid_o, value_o and mismatch_o; latency is exactly 2 cycles from valid_i to valid_o.
REQ-018 SHALL accept one sample per cycle with no backpressure; bubbles (valid_i=0) propagate as valid_o=0, and value_o and mismatch_o hold their last values.
REQ-019 SHALL increment err_count_o when valid_o=1 and mismatch_o=1, saturating at 255 with no wrap.
REQ-020 SHALL keep per-element usage counters, each WIN_LOG2+1 bits, where counter k increments when the S1 sample is valid and elem bit k=1.
REQ-021 SHALL keep a window counter, WIN_LOG2+1 bits, that increments once per valid S1 sample.
REQ-022 SHALL implement FSM states ACCUM and REPORT; reset enters ACCUM.
REQ-023 SHALL transition ACCUM->REPORT on the cycle the window counter reaches 2^WIN_LOG2, counting the sample that completes the window.
REQ-024 SHALL, in REPORT for one cycle, register spread_o = max(usage) - min(usage), pulse window_done_o, and return to ACCUM.
REQ-025 SHALL, in REPORT, load the usage and window counters with the contribution of the concurrent S1 sample only (0 or 1), so no sample is lost across the window boundary.
REQ-026 SHALL, on clear_stats_i=1, zero the usage counters, window counter and err_count_o next cycle and force ACCUM; clear overrides any increment in the same cycle.
REQ-027 SHALL suppress window_done_o and hold spread_o if clear_stats_i is asserted in REPORT.
REQ-028 SHALL NOT let clear_stats_i affect the S1/S2 data pipeline.
REQ-029 SHALL treat all-ones elem_i (popcount NUM_ELEM) and all-zeros elem_i as legal values.
REQ-030 SHALL compare ref_value_i > NUM_ELEM normally, which always yields mismatch_o=1.

Reset
REQ-031 SHALL, while reset_i=1, asynchronously clear every register: valid_o=0, value_o=0, mismatch_o=0, err_count_o=0, spread_o=0, window_done_o=0, all counters 0, FSM=ACCUM.
REQ-032 SHALL, on reset asserted mid-window, discard all in-flight pipeline samples and partial statistics; the first valid_o after release comes 2 cycles after the first post-release valid_i.

Verification
REQ-033 Bench SHALL cover: reset, then valid_i=1, elem_i=16'h0007, ref=3 -> 2 cycles later valid_o=1, value_o=3, mismatch_o=0, err_count_o stays 0.
REQ-034 Bench SHALL cover: elem_i=16'h00FF, ref=5 -> value_o=8, mismatch_o=1, err_count_o increments by 1; 300 such samples -> err_count_o=255 and holds.
REQ-035 Bench SHALL cover: elem_i=16'hFFFF then 16'h0000 -> value_o=16 then 0, with no wrap.
REQ-036 Bench SHALL cover: 256 valid samples of elem_i=16'h0001 -> single window_done_o pulse, spread_o=256; the 257th sample issued in the REPORT cycle is counted as the first sample of the next window.
REQ-037 Bench SHALL cover: 256 samples rotating one-hot elem_i (bit k = sample mod 16) -> spread_o=0; the same run with clear_stats_i in the REPORT cycle -> no window_done_o and spread_o unchanged.
REQ-038 Bench SHALL cover: reset_i pulsed mid-window with 2 samples in flight -> all outputs 0 immediately, no valid_o from the flushed samples.

Source files
------------

// File: rtl/dem_element_decoder.sv
// -----------------------------------------------------------------------------
// dem_element_decoder
//
// Purpose:
//   Monitors the unit-element enables coming out of a dynamic-element-matching
//   switching tree. Each sample's element vector is popcounted back into a code
//   and compared with the quantized value that produced it. Mismatched samples
//   are counted. Per-element usage is collected over fixed windows so that the
//   spread between the most and least used elements can be reported.
//
// Ports:
//   clk_i          - single clock, rising-edge triggered
//   reset_i        - asynchronous, active-high reset
//   valid_i        - elem_i / ref_value_i carry a sample this cycle
//   elem_i         - unit-element enables, bit k = element k on
//   ref_value_i    - quantized value aligned with elem_i
//   clear_stats_i  - synchronous clear of usage, window and error statistics
//   valid_o        - value_o / mismatch_o are fresh this cycle (2-cycle latency)
//   value_o        - popcount of the sample's elem_i
//   mismatch_o     - value_o differs from the sample's ref_value_i
//   err_count_o    - saturating count of mismatched samples
//   spread_o       - max minus min element usage of the last completed window
//   window_done_o  - one-cycle pulse when spread_o is updated
// -----------------------------------------------------------------------------
module dem_element_decoder #(
    parameter int NUM_ELEM = 16,
    parameter int WIDTH    = 5,
    parameter int WIN_LOG2 = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic [NUM_ELEM-1:0] elem_i,
    input  logic [WIDTH-1:0]    ref_value_i,
    input  logic                clear_stats_i,
    output logic                valid_o,
    output logic [WIDTH-1:0]    value_o,
    output logic                mismatch_o,
    output logic [7:0]          err_count_o,
    output logic [WIN_LOG2:0]   spread_o,
    output logic                window_done_o
);

    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] WIN_FULL = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic {
        ACCUM,
        REPORT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                s1_valid;
    logic [NUM_ELEM-1:0] s1_elem;
    logic [WIDTH-1:0]    s1_ref;
    logic [WIDTH-1:0]    s1_popcount;

    logic [CW-1:0] usage [NUM_ELEM];
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] win_next;
    logic [CW-1:0] usage_max;
    logic [CW-1:0] usage_min;

    // First pipeline stage: capture the raw sample so both the decode path
    // and the statistics path work from the same registered copy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_elem  <= '0;
            s1_ref   <= '0;
        end else begin
            s1_valid <= valid_i;
            s1_elem  <= elem_i;
            s1_ref   <= ref_value_i;
        end
    end

    // Reconstruct the code by counting enabled elements. WIDTH is wide enough
    // to hold NUM_ELEM, so the all-ones vector does not wrap.
    always_comb begin
        s1_popcount = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            s1_popcount = s1_popcount + WIDTH'(s1_elem[k]);
        end
    end

    // Second pipeline stage: register the decoded value and the comparison.
    // On bubbles only the valid flag moves, so value/mismatch hold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o    <= 1'b0;
            value_o    <= '0;
            mismatch_o <= 1'b0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                value_o    <= s1_popcount;
                mismatch_o <= (s1_popcount != s1_ref);
            end
        end
    end

    // Error counter works off the registered outputs, so it lags valid_o by
    // one cycle. It sticks at 255 rather than wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_count_o <= '0;
        end else if (clear_stats_i) begin
            err_count_o <= '0;
        end else if (valid_o && mismatch_o && (err_count_o != 8'hFF)) begin
            err_count_o <= err_count_o + 8'd1;
        end
    end

    // Window FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The window closes on the same edge that counts its
    // last sample, so REPORT sees the complete usage totals.
    always_comb begin
        state_d  = state_q;
        win_next = win_cnt + CW'(s1_valid);
        case (state_q)
            ACCUM:   if (win_next == WIN_FULL) state_d = REPORT;
            REPORT:  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (clear_stats_i) begin
            state_d = ACCUM;
        end
    end

    // Usage and window counters. In REPORT they restart from the sample that
    // is sitting in S1 that cycle, so nothing falls between windows.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            win_cnt <= '0;
            for (int k = 0; k < NUM_ELEM; k++) begin
                usage[k] <= '0;
            end
        end else if (clear_stats_i) begin
            win_cnt <= '0;
            for (int k = 0; k < NUM_ELEM; k++) begin
                usage[k] <= '0;
            end
        end else if (state_q == REPORT) begin
            win_cnt <= CW'(s1_valid);
            for (int k = 0; k < NUM_ELEM; k++) begin
                usage[k] <= CW'(s1_valid & s1_elem[k]);
            end
        end else begin
            win_cnt <= win_next;
            for (int k = 0; k < NUM_ELEM; k++) begin
                usage[k] <= usage[k] + CW'(s1_valid & s1_elem[k]);
            end
        end
    end

    // Largest and smallest per-element usage over the current window.
    always_comb begin
        usage_max = usage[0];
        usage_min = usage[0];
        for (int k = 1; k < NUM_ELEM; k++) begin
            if (usage[k] > usage_max) usage_max = usage[k];
            if (usage[k] < usage_min) usage_min = usage[k];
        end
    end

    // Publish the spread at the end of each window. A clear landing in REPORT
    // abandons that window, so neither the pulse nor the update happens.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            spread_o      <= '0;
            window_done_o <= 1'b0;
        end else begin
            window_done_o <= 1'b0;
            if ((state_q == REPORT) && !clear_stats_i) begin
                spread_o      <= usage_max - usage_min;
                window_done_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dem_element_decoder.sv
// -----------------------------------------------------------------------------
// tb_dem_element_decoder
//
// Purpose:
//   Self-checking bench for dem_element_decoder. Directed scenarios plus a
//   randomized run are checked every cycle against a behavioural model that
//   works from whole samples: popcounts, per-element totals over a window of
//   256 samples, and a saturating error tally.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_dem_element_decoder;

    localparam int NUM_ELEM = 16;
    localparam int WIDTH    = 5;
    localparam int WIN_LOG2 = 8;
    localparam int WIN      = 1 << WIN_LOG2;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                valid_i;
    logic [NUM_ELEM-1:0] elem_i;
    logic [WIDTH-1:0]    ref_value_i;
    logic                clear_stats_i;
    logic                valid_o;
    logic [WIDTH-1:0]    value_o;
    logic                mismatch_o;
    logic [7:0]          err_count_o;
    logic [WIN_LOG2:0]   spread_o;
    logic                window_done_o;

    int checks_total  = 0;
    int checks_passed = 0;
    int done_seen     = 0;

    // Model state: the sample currently held in the first stage, the expected
    // outputs, and the per-element totals of the open window.
    bit                  m_prev_valid;
    logic [NUM_ELEM-1:0] m_prev_elem;
    logic [WIDTH-1:0]    m_prev_ref;
    bit                  m_valid;
    int                  m_value;
    bit                  m_mis;
    int                  m_err;
    int                  m_spread;
    bit                  m_done;
    int                  m_usage [NUM_ELEM];
    int                  m_total;
    bit                  m_pending;
    int                  m_pending_spread;

    dem_element_decoder #(
        .NUM_ELEM (NUM_ELEM),
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .valid_i       (valid_i),
        .elem_i        (elem_i),
        .ref_value_i   (ref_value_i),
        .clear_stats_i (clear_stats_i),
        .valid_o       (valid_o),
        .value_o       (value_o),
        .mismatch_o    (mismatch_o),
        .err_count_o   (err_count_o),
        .spread_o      (spread_o),
        .window_done_o (window_done_o)
    );

    // Free-running 100 MHz clock.
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_valid     = 1'b0;
        m_prev_elem      = '0;
        m_prev_ref       = '0;
        m_valid          = 1'b0;
        m_value          = 0;
        m_mis            = 1'b0;
        m_err            = 0;
        m_spread         = 0;
        m_done           = 1'b0;
        m_total          = 0;
        m_pending        = 1'b0;
        m_pending_spread = 0;
        for (int k = 0; k < NUM_ELEM; k++) m_usage[k] = 0;
    endtask

    // Advance the model by one clock edge. The sample in the first stage is
    // decoded and counted into the window; clr is the clear seen at this edge.
    task automatic model_step(input bit clr);
        bit old_valid;
        bit old_mis;
        int mx;
        int mn;
        old_valid = m_valid;
        old_mis   = m_mis;
        if (clr) m_err = 0;
        else if (old_valid && old_mis && m_err < 255) m_err++;

        m_valid = m_prev_valid;
        if (m_prev_valid) begin
            m_value = $countones(m_prev_elem);
            m_mis   = (m_value != int'(m_prev_ref));
        end

        m_done = 1'b0;
        if (clr) begin
            for (int k = 0; k < NUM_ELEM; k++) m_usage[k] = 0;
            m_total   = 0;
            m_pending = 1'b0;
        end else begin
            if (m_pending) begin
                m_done    = 1'b1;
                m_spread  = m_pending_spread;
                m_pending = 1'b0;
            end
            if (m_prev_valid) begin
                for (int k = 0; k < NUM_ELEM; k++) m_usage[k] += int'(m_prev_elem[k]);
                m_total++;
                if (m_total == WIN) begin
                    mx = m_usage[0];
                    mn = m_usage[0];
                    for (int k = 1; k < NUM_ELEM; k++) begin
                        if (m_usage[k] > mx) mx = m_usage[k];
                        if (m_usage[k] < mn) mn = m_usage[k];
                    end
                    m_pending        = 1'b1;
                    m_pending_spread = mx - mn;
                    for (int k = 0; k < NUM_ELEM; k++) m_usage[k] = 0;
                    m_total = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        checkOutput("valid_o", int'(valid_o), int'(m_valid));
        checkOutput("value_o", int'(value_o), m_value);
        checkOutput("mismatch_o", int'(mismatch_o), int'(m_mis));
        checkOutput("err_count_o", int'(err_count_o), m_err);
        checkOutput("window_done_o", int'(window_done_o), int'(m_done));
        checkOutput("spread_o", int'(spread_o), m_spread);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare all
    // outputs 1 ns later against the model.
    task automatic applyStimulus(input bit v, input logic [NUM_ELEM-1:0] e,
                                 input logic [WIDTH-1:0] r, input bit clr);
        valid_i       = v;
        elem_i        = e;
        ref_value_i   = r;
        clear_stats_i = clr;
        @(posedge clk_i);
        #1;
        model_step(clr);
        m_prev_valid = v;
        m_prev_elem  = e;
        m_prev_ref   = r;
        if (window_done_o) done_seen++;
        check_all();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset: outputs must drop without waiting for a clock.
    task automatic do_reset();
        valid_i       = 1'b0;
        elem_i        = '0;
        ref_value_i   = '0;
        clear_stats_i = 1'b0;
        reset_i       = 1'b1;
        #1;
        checkOutput("rst_valid_o", int'(valid_o), 0);
        checkOutput("rst_value_o", int'(value_o), 0);
        checkOutput("rst_mismatch_o", int'(mismatch_o), 0);
        checkOutput("rst_err_count_o", int'(err_count_o), 0);
        checkOutput("rst_spread_o", int'(spread_o), 0);
        checkOutput("rst_window_done_o", int'(window_done_o), 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        logic [NUM_ELEM-1:0] e;
        logic [WIDTH-1:0]    r;
        bit                  v;
        bit                  c;

        do_reset();

        // Matching sample: value 3, no mismatch, error count stays 0.
        applyStimulus(1'b1, 16'h0007, 5'd3, 1'b0);
        bubbles(3);

        // Repeated mismatches drive the error count into saturation.
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 16'h00FF, 5'd5, 1'b0);
        bubbles(3);
        checkOutput("err_saturated", int'(err_count_o), 255);

        // Extremes of the element vector decode without wrapping.
        applyStimulus(1'b1, 16'hFFFF, 5'd16, 1'b0);
        applyStimulus(1'b1, 16'h0000, 5'd0, 1'b0);
        bubbles(3);

        // Two back-to-back windows of element 0 only; the sample issued in
        // the REPORT cycle must open the second window.
        applyStimulus(1'b0, '0, '0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 2 * WIN; i++) applyStimulus(1'b1, 16'h0001, 5'd1, 1'b0);
        bubbles(3);
        checkOutput("window_pulses", done_seen, 2);
        checkOutput("window_spread", int'(spread_o), 256);

        // Balanced one-hot rotation, with a clear landing in the REPORT cycle.
        applyStimulus(1'b0, '0, '0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < WIN; i++) begin
            e = 16'h0001 << (i % NUM_ELEM);
            applyStimulus(1'b1, e, 5'd1, 1'b0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        bubbles(3);
        checkOutput("clear_in_report_pulses", done_seen, 0);
        checkOutput("clear_in_report_spread", int'(spread_o), 256);

        // Same rotation without a clear: perfectly balanced usage.
        done_seen = 0;
        for (int i = 0; i < WIN; i++) begin
            e = 16'h0001 << (i % NUM_ELEM);
            applyStimulus(1'b1, e, 5'd1, 1'b0);
        end
        bubbles(3);
        checkOutput("rotation_pulses", done_seen, 1);
        checkOutput("rotation_spread", int'(spread_o), 0);

        // Randomized traffic with bubbles, bad references and rare clears.
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            e = NUM_ELEM'($urandom);
            if ($urandom_range(0, 1) == 1) r = WIDTH'($countones(e));
            else r = WIDTH'($urandom_range(0, 31));
            c = ($urandom_range(0, 299) == 0);
            applyStimulus(v, e, r, c);
        end
        bubbles(3);

        // Reset with two samples in flight: they must never reach valid_o.
        applyStimulus(1'b1, 16'h0F0F, 5'd8, 1'b0);
        applyStimulus(1'b1, 16'h0003, 5'd7, 1'b0);
        do_reset();
        bubbles(4);
        applyStimulus(1'b1, 16'h001F, 5'd5, 1'b0);
        bubbles(3);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
